// File: rtl/sram_arbiter.sv
// Arbitrates one record write port and two read ports (play, visualiser) onto an async SRAM.
// Define SRAM_ARB_RR_EN to round-robin the two readers; default build is fixed priority play > vis.
module sram_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rec_req,
  input  logic [19:0] i_rec_addr,
  input  logic [15:0] i_rec_wdata,
  output logic        o_rec_ack,
  input  logic        i_play_req,
  input  logic [19:0] i_play_addr,
  output logic        o_play_ack,
  input  logic        i_vis_req,
  input  logic [19:0] i_vis_addr,
  output logic        o_vis_ack,
  output logic [15:0] o_rdata,
  output logic [19:0] o_SRAM_ADDR,
  output logic        o_SRAM_WE_N,
  output logic        o_SRAM_OE_N,
  output logic [15:0] o_SRAM_DQ_OUT,
  output logic        o_SRAM_DQ_OE,
  input  logic [15:0] i_SRAM_DQ,
  output logic        o_busy,
  output logic [1:0]  o_grant_id
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RECOVER} state_t;
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_REC  = 2'd1,
    GNT_PLAY = 2'd2,
    GNT_VIS  = 2'd3
  } gnt_t;

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  gnt_t        gnt_q, gnt_d, win;
  logic [19:0] addr_q, addr_d, win_addr;
  logic [15:0] dq_out_q, dq_out_d;
  logic [15:0] rdata_q, rdata_d;
  logic        we_n_q, we_n_d;
  logic        oe_n_q, oe_n_d;
  logic        dq_oe_q, dq_oe_d;
  logic        busy_q, busy_d;
  logic        rec_ack_q, rec_ack_d;
  logic        play_ack_q, play_ack_d;
  logic        vis_ack_q, vis_ack_d;
`ifdef SRAM_ARB_RR_EN
  logic        ptr_q, ptr_d;  // 0: play preferred, 1: vis preferred
`endif

  // Record always wins; readers split by fixed priority or the round-robin pointer.
  always_comb begin
    win = GNT_NONE;
    if (i_rec_req) win = GNT_REC;
`ifdef SRAM_ARB_RR_EN
    else if (i_play_req && i_vis_req) win = ptr_q ? GNT_VIS : GNT_PLAY;
`endif
    else if (i_play_req) win = GNT_PLAY;
    else if (i_vis_req) win = GNT_VIS;
  end

  always_comb begin
    case (win)
      GNT_REC:  win_addr = i_rec_addr;
      GNT_PLAY: win_addr = i_play_addr;
      GNT_VIS:  win_addr = i_vis_addr;
      default:  win_addr = 20'h0;
    endcase
  end

  // NOTE: every _d gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    addr_d     = addr_q;
    dq_out_d   = dq_out_q;
    rdata_d    = rdata_q;
    we_n_d     = 1'b1;
    oe_n_d     = 1'b1;
    dq_oe_d    = 1'b0;
    busy_d     = 1'b0;
    rec_ack_d  = 1'b0;
    play_ack_d = 1'b0;
    vis_ack_d  = 1'b0;
`ifdef SRAM_ARB_RR_EN
    ptr_d      = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        gnt_d = GNT_NONE;
        if (win != GNT_NONE) begin
          state_d = S_ACCESS;
          gnt_d   = win;
          addr_d  = win_addr;
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
          if (win == GNT_REC) begin
            dq_out_d = i_rec_wdata;
            we_n_d   = 1'b0;
            dq_oe_d  = 1'b1;
          end else begin
            oe_n_d = 1'b0;
          end
`ifdef SRAM_ARB_RR_EN
          if (win == GNT_PLAY) ptr_d = 1'b1;
          else if (win == GNT_VIS) ptr_d = 1'b0;
`endif
        end
      end
      S_ACCESS: begin
        busy_d = 1'b1;
        if (cnt_q == LAST_CNT) begin
          // Strobes drop into RECOVER; write data stays driven for hold time.
          state_d    = S_RECOVER;
          cnt_d      = 4'd0;
          dq_oe_d    = (gnt_q == GNT_REC);
          if (gnt_q != GNT_REC) rdata_d = i_SRAM_DQ;
          rec_ack_d  = (gnt_q == GNT_REC);
          play_ack_d = (gnt_q == GNT_PLAY);
          vis_ack_d  = (gnt_q == GNT_VIS);
        end else begin
          cnt_d   = cnt_q + 4'd1;
          we_n_d  = (gnt_q != GNT_REC);
          oe_n_d  = (gnt_q == GNT_REC);
          dq_oe_d = (gnt_q == GNT_REC);
        end
      end
      S_RECOVER: begin
        state_d = S_IDLE;
        gnt_d   = GNT_NONE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = GNT_NONE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      gnt_q      <= GNT_NONE;
      addr_q     <= 20'h0;
      dq_out_q   <= 16'h0;
      rdata_q    <= 16'h0;
      we_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      dq_oe_q    <= 1'b0;
      busy_q     <= 1'b0;
      rec_ack_q  <= 1'b0;
      play_ack_q <= 1'b0;
      vis_ack_q  <= 1'b0;
`ifdef SRAM_ARB_RR_EN
      ptr_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      addr_q     <= addr_d;
      dq_out_q   <= dq_out_d;
      rdata_q    <= rdata_d;
      we_n_q     <= we_n_d;
      oe_n_q     <= oe_n_d;
      dq_oe_q    <= dq_oe_d;
      busy_q     <= busy_d;
      rec_ack_q  <= rec_ack_d;
      play_ack_q <= play_ack_d;
      vis_ack_q  <= vis_ack_d;
`ifdef SRAM_ARB_RR_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign o_rec_ack     = rec_ack_q;
  assign o_play_ack    = play_ack_q;
  assign o_vis_ack     = vis_ack_q;
  assign o_rdata       = rdata_q;
  assign o_SRAM_ADDR   = addr_q;
  assign o_SRAM_WE_N   = we_n_q;
  assign o_SRAM_OE_N   = oe_n_q;
  assign o_SRAM_DQ_OUT = dq_out_q;
  assign o_SRAM_DQ_OE  = dq_oe_q;
  assign o_busy        = busy_q;
  assign o_grant_id    = gnt_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: stimulus queues expected acks and strobe bursts,
// two negedge monitors pop and compare them against the DUT.
module tb_sram_arbiter;

  localparam int AC = 2;
  localparam logic [1:0] P_REC  = 2'd1;
  localparam logic [1:0] P_PLAY = 2'd2;
  localparam logic [1:0] P_VIS  = 2'd3;

  typedef struct {
    logic [1:0]  port;
    int          cyc;
    logic [15:0] rdata;
  } ack_exp_t;

  typedef struct {
    logic        we;
    logic [19:0] addr;
    logic [15:0] data;
    int          len;
    logic [1:0]  gnt;
  } stb_exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_rec_req, i_play_req, i_vis_req;
  logic [19:0] i_rec_addr, i_play_addr, i_vis_addr;
  logic [15:0] i_rec_wdata;
  logic        o_rec_ack, o_play_ack, o_vis_ack;
  logic [15:0] o_rdata;
  logic [19:0] o_SRAM_ADDR;
  logic        o_SRAM_WE_N, o_SRAM_OE_N, o_SRAM_DQ_OE;
  logic [15:0] o_SRAM_DQ_OUT;
  logic [15:0] i_SRAM_DQ;
  logic        o_busy;
  logic [1:0]  o_grant_id;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  ack_exp_t ack_q[$];
  stb_exp_t stb_q[$];
  logic [15:0] mem [256];

  sram_arbiter #(.ACCESS_CYCLES(AC)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_rec_req(i_rec_req), .i_rec_addr(i_rec_addr), .i_rec_wdata(i_rec_wdata), .o_rec_ack(o_rec_ack),
    .i_play_req(i_play_req), .i_play_addr(i_play_addr), .o_play_ack(o_play_ack),
    .i_vis_req(i_vis_req), .i_vis_addr(i_vis_addr), .o_vis_ack(o_vis_ack),
    .o_rdata(o_rdata),
    .o_SRAM_ADDR(o_SRAM_ADDR), .o_SRAM_WE_N(o_SRAM_WE_N), .o_SRAM_OE_N(o_SRAM_OE_N),
    .o_SRAM_DQ_OUT(o_SRAM_DQ_OUT), .o_SRAM_DQ_OE(o_SRAM_DQ_OE), .i_SRAM_DQ(i_SRAM_DQ),
    .o_busy(o_busy), .o_grant_id(o_grant_id)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Simple SRAM model: write on rising edge while WE_N low, read combinationally.
  always @(posedge i_clk) if (!o_SRAM_WE_N) mem[o_SRAM_ADDR[7:0]] <= o_SRAM_DQ_OUT;
  assign i_SRAM_DQ = !o_SRAM_OE_N ? mem[o_SRAM_ADDR[7:0]] : 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic drive_req(input logic [1:0] p, input logic v);
    case (p)
      P_REC:   i_rec_req  = v;
      P_PLAY:  i_play_req = v;
      default: i_vis_req  = v;
    endcase
  endtask

  // One isolated request from IDLE; returns with the DUT back in IDLE.
  task automatic single(input logic [1:0] p, input logic [19:0] a, input logic [15:0] wd,
                        input logic [15:0] exp_rd);
    int t;
    t = cyc;
    case (p)
      P_REC:   begin i_rec_addr = a; i_rec_wdata = wd; end
      P_PLAY:  i_play_addr = a;
      default: i_vis_addr = a;
    endcase
    drive_req(p, 1'b1);
    ack_q.push_back('{p, t + AC + 1, exp_rd});
    stb_q.push_back('{(p == P_REC), a, wd, AC, p});
    wait_cycles(1);
    drive_req(p, 1'b0);
    i_rec_addr  = 20'hFFFFF;
    i_play_addr = 20'hFFFFF;
    i_vis_addr  = 20'hFFFFF;
    i_rec_wdata = 16'hDEAD;
    wait_cycles(AC + 1);
  endtask

  // Ack monitor: compare each ack against the oldest expectation.
  logic chk_idle = 1'b0;
  always @(negedge i_clk) begin : ack_mon
    ack_exp_t   e;
    logic [1:0] p;
    if (chk_idle) begin
      check("idle_busy", 32'(o_busy), 32'd0);
      check("idle_grant", 32'(o_grant_id), 32'd0);
    end
    chk_idle <= 1'b0;
    if (o_rec_ack || o_play_ack || o_vis_ack) begin
      p = o_rec_ack ? P_REC : (o_play_ack ? P_PLAY : P_VIS);
      chk_idle <= 1'b1;
      if (ack_q.size() == 0) begin
        check("unexpected_ack", 32'(p), 32'd0);
      end else begin
        e = ack_q.pop_front();
        check("ack_port", 32'(p), 32'(e.port));
        check("ack_cycle", 32'(cyc), 32'(e.cyc));
        check("ack_rdata", 32'(o_rdata), 32'(e.rdata));
        check("ack_busy", 32'(o_busy), 32'd1);
        check("ack_grant", 32'(o_grant_id), 32'(e.port));
        check("ack_strobes_off", 32'({o_SRAM_WE_N, o_SRAM_OE_N}), 32'd3);
      end
    end
  end

  // Strobe monitor: measure each WE_N/OE_N low burst and check protocol invariants.
  logic        in_run = 1'b0;
  int          run_len = 0;
  logic        run_we, run_dq_oe, run_busy;
  logic [19:0] run_addr;
  logic [15:0] run_data;
  logic [1:0]  run_gnt;
  always @(negedge i_clk) begin : stb_mon
    stb_exp_t e;
    logic     strobe;
    check("ack_onehot", 32'($countones({o_rec_ack, o_play_ack, o_vis_ack}) <= 1), 32'd1);
    check("we_oe_exclusive", 32'(o_SRAM_WE_N || o_SRAM_OE_N), 32'd1);
    check("no_dq_oe_on_read", 32'(o_SRAM_OE_N || !o_SRAM_DQ_OE), 32'd1);
    strobe = !o_SRAM_WE_N || !o_SRAM_OE_N;
    if (strobe) begin
      if (!in_run) begin
        in_run    <= 1'b1;
        run_len   <= 1;
        run_we    <= !o_SRAM_WE_N;
        run_addr  <= o_SRAM_ADDR;
        run_data  <= o_SRAM_DQ_OUT;
        run_gnt   <= o_grant_id;
        run_dq_oe <= o_SRAM_DQ_OE;
        run_busy  <= o_busy;
      end else begin
        run_len <= run_len + 1;
      end
    end else if (in_run) begin
      in_run <= 1'b0;
      if (stb_q.size() == 0) begin
        check("unexpected_strobe", 32'(run_gnt), 32'd0);
      end else begin
        e = stb_q.pop_front();
        check("stb_we", 32'(run_we), 32'(e.we));
        check("stb_addr", 32'(run_addr), 32'(e.addr));
        check("stb_len", 32'(run_len), 32'(e.len));
        check("stb_grant", 32'(run_gnt), 32'(e.gnt));
        check("stb_busy", 32'(run_busy), 32'd1);
        if (e.we) begin
          check("stb_wdata", 32'(run_data), 32'(e.data));
          check("stb_dq_oe", 32'(run_dq_oe), 32'd1);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t;
    i_rst = 1'b1;
    i_rec_req = 1'b0; i_play_req = 1'b0; i_vis_req = 1'b0;
    i_rec_addr = 20'h0; i_play_addr = 20'h0; i_vis_addr = 20'h0; i_rec_wdata = 16'h0;
    wait_cycles(3);
    check("rst_we_n", 32'(o_SRAM_WE_N), 32'd1);
    check("rst_oe_n", 32'(o_SRAM_OE_N), 32'd1);
    check("rst_dq_oe", 32'(o_SRAM_DQ_OE), 32'd0);
    check("rst_addr", 32'(o_SRAM_ADDR), 32'd0);
    check("rst_dq_out", 32'(o_SRAM_DQ_OUT), 32'd0);
    check("rst_rdata", 32'(o_rdata), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_grant", 32'(o_grant_id), 32'd0);
    check("rst_acks", 32'({o_rec_ack, o_play_ack, o_vis_ack}), 32'd0);
    i_rst = 1'b0;

    // Write, then read it back on both readers (the vis read re-centres the RR pointer on play).
    single(P_REC,  20'h00010, 16'hA5A5, 16'h0000);
    single(P_PLAY, 20'h00010, 16'h0000, 16'hA5A5);
    single(P_VIS,  20'h00010, 16'h0000, 16'hA5A5);

    // Contention: all three at cycle t -> rec, play, vis with acks at t+3, t+7, t+11.
    t = cyc;
    i_rec_addr = 20'h00030; i_rec_wdata = 16'h1234;
    i_play_addr = 20'h00010; i_vis_addr = 20'h00030;
    i_rec_req = 1'b1; i_play_req = 1'b1; i_vis_req = 1'b1;
    ack_q.push_back('{P_REC,  t + 3,  16'hA5A5});
    ack_q.push_back('{P_PLAY, t + 7,  16'hA5A5});
    ack_q.push_back('{P_VIS,  t + 11, 16'h1234});
    stb_q.push_back('{1'b1, 20'h00030, 16'h1234, AC, P_REC});
    stb_q.push_back('{1'b0, 20'h00010, 16'h0000, AC, P_PLAY});
    stb_q.push_back('{1'b0, 20'h00030, 16'h0000, AC, P_VIS});
    wait_cycles(1);
    i_rec_req = 1'b0; i_rec_addr = 20'hFFFFF; i_rec_wdata = 16'hDEAD;
    wait_cycles(4);
    i_play_req = 1'b0;
    wait_cycles(4);
    i_vis_req = 1'b0;
    wait_cycles(3);

    // Policy: play and vis held high across four grants.
    t = cyc;
    i_play_addr = 20'h00010; i_vis_addr = 20'h00030;
    i_play_req = 1'b1; i_vis_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef SRAM_ARB_RR_EN
      if (k % 2 == 0) begin
        ack_q.push_back('{P_PLAY, t + 4*k + 3, 16'hA5A5});
        stb_q.push_back('{1'b0, 20'h00010, 16'h0000, AC, P_PLAY});
      end else begin
        ack_q.push_back('{P_VIS, t + 4*k + 3, 16'h1234});
        stb_q.push_back('{1'b0, 20'h00030, 16'h0000, AC, P_VIS});
      end
`else
      ack_q.push_back('{P_PLAY, t + 4*k + 3, 16'hA5A5});
      stb_q.push_back('{1'b0, 20'h00010, 16'h0000, AC, P_PLAY});
`endif
    end
    wait_cycles(13);
    i_play_req = 1'b0; i_vis_req = 1'b0;
    wait_cycles(3);

    // Reset during the second ACCESS cycle of a write: no ack, strobes off next cycle.
    t = cyc;
    i_rec_addr = 20'h00040; i_rec_wdata = 16'hBEEF;
    i_rec_req = 1'b1;
    stb_q.push_back('{1'b1, 20'h00040, 16'hBEEF, 2, P_REC});
    wait_cycles(1);
    i_rec_req = 1'b0;
    wait_cycles(1);
    i_rst = 1'b1;
    wait_cycles(1);
    check("abort_cycle", 32'(cyc), 32'(t + 3));
    check("abort_we_n", 32'(o_SRAM_WE_N), 32'd1);
    check("abort_dq_oe", 32'(o_SRAM_DQ_OE), 32'd0);
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_grant", 32'(o_grant_id), 32'd0);
    check("abort_rec_ack", 32'(o_rec_ack), 32'd0);
    check("abort_rdata", 32'(o_rdata), 32'd0);
    i_rst = 1'b0;

    // Re-request after reset completes normally.
    single(P_REC,  20'h00040, 16'h5A5A, 16'h0000);
    single(P_PLAY, 20'h00040, 16'h0000, 16'h5A5A);

    wait_cycles(5);
    check("ack_queue_drained", 32'(ack_q.size()), 32'd0);
    check("strobe_queue_drained", 32'(stb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
